systolic_tile_engine: RTL and testbench

- Parametrised, self-contained output-stationary systolic matrix-multiply tile: computes C = A x B for an N x N output tile with K streamed (arbitrary K, 1..2^K_W-1).
- Contains input skew, the N x N MAC array, a flush/drain controller and row-serial output.
- Valid/ready handshakes on both sides replace the fixed-timing last-pulse/counter scheme.
- Adds signed/unsigned mode, optional saturation and an overflow flag.
- Sits between the operand fetch streams and the result write-back stream.

---
 rtl/systolic_tile_engine.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_systolic_tile_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_engine.sv
// Output-stationary N x N systolic matrix-multiply tile: C = A x B over K streamed beats.
// Operands enter with a diagonal skew, results drain one row per handshake.
module systolic_tile_engine #(
  parameter int unsigned N        = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 24,
  parameter bit          SIGNED   = 1'b1,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned K_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_last_i,
  input  logic [N*DATA_W-1:0]   a_i,
  input  logic [N*DATA_W-1:0]   b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic [N*ACC_W-1:0]    c_o,
  output logic                  ovf_o,
  output logic                  busy_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeed  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam int unsigned FlushW = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam int unsigned RowW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [FlushW-1:0] FlushLast = FlushW'(2 * N - 2);
  localparam logic [RowW-1:0]   LastRow   = RowW'(N - 1);
  // Beat index at which the tile is force-terminated so the counter never wraps.
  localparam logic [K_W-1:0]    BeatLimit = {K_W{1'b1}} - K_W'(1);

  logic [1:0]        state_q, state_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [K_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic              ovf_q, ovf_d;

  logic accept;
  logic last_beat;
  logic drain_hs;
  logic drain_done;
  logic [N*N-1:0] pe_ovf;

  // Skewed operands entering the array edges.
  logic [DATA_W-1:0] a_sk [N];
  logic [DATA_W-1:0] b_sk [N];
  logic              av_sk [N];
  logic              bv_sk [N];

  // Operand inputs seen by PE(i,j).
  logic [DATA_W-1:0] a_pe  [N][N];
  logic [DATA_W-1:0] b_pe  [N][N];
  logic              av_pe [N][N];
  logic              bv_pe [N][N];
  logic [ACC_W-1:0]  acc   [N][N];

  assign in_ready_o  = (state_q == StIdle) || (state_q == StFeed);
  assign accept      = in_valid_i && in_ready_o;
  assign last_beat   = in_last_i || (beat_cnt_q == BeatLimit);
  assign drain_hs    = (state_q == StDrain) && out_ready_i;
  assign drain_done  = drain_hs && (row_q == LastRow);

  assign out_valid_o = (state_q == StDrain);
  assign out_last_o  = out_valid_o && (row_q == LastRow);
  assign ovf_o       = ovf_q;
  assign busy_o      = (state_q != StIdle);

  // Next-state logic for the tile controller and its counters.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      StIdle, StFeed: begin
        if (accept) begin
          if (last_beat) begin
            state_d    = StFlush;
            beat_cnt_d = '0;
          end else begin
            state_d    = StFeed;
            beat_cnt_d = beat_cnt_q + K_W'(1);
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) begin
          state_d     = StDrain;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FlushW'(1);
        end
      end
      StDrain: begin
        if (drain_hs) begin
          if (row_q == LastRow) begin
            state_d = StIdle;
            row_d   = '0;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky tile overflow: cleared by the first beat of a new tile.
  always_comb begin
    ovf_d = ((state_q == StIdle) && accept) ? 1'b0 : ovf_q;
    ovf_d = ovf_d | (|pe_ovf);
  end

  // Controller state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      row_q       <= '0;
      beat_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      beat_cnt_q  <= beat_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Row i of A and column i of B share the same i-cycle delay line.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] a_lane;
    logic [DATA_W-1:0] b_lane;
    assign a_lane = a_i[i*DATA_W +: DATA_W];
    assign b_lane = b_i[i*DATA_W +: DATA_W];

    if (i == 0) begin : g_direct
      assign a_sk[i]  = a_lane;
      assign b_sk[i]  = b_lane;
      assign av_sk[i] = accept;
      assign bv_sk[i] = accept;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sh_q [i];
      logic [DATA_W-1:0] b_sh_q [i];
      logic              av_sh_q [i];
      logic              bv_sh_q [i];

      // Shift operands and their valid bits one stage per cycle.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int d = 0; d < i; d++) begin
            a_sh_q[d]  <= '0;
            b_sh_q[d]  <= '0;
            av_sh_q[d] <= 1'b0;
            bv_sh_q[d] <= 1'b0;
          end
        end else begin
          a_sh_q[0]  <= a_lane;
          b_sh_q[0]  <= b_lane;
          av_sh_q[0] <= accept;
          bv_sh_q[0] <= accept;
          for (int d = 1; d < i; d++) begin
            a_sh_q[d]  <= a_sh_q[d-1];
            b_sh_q[d]  <= b_sh_q[d-1];
            av_sh_q[d] <= av_sh_q[d-1];
            bv_sh_q[d] <= bv_sh_q[d-1];
          end
        end
      end

      assign a_sk[i]  = a_sh_q[i-1];
      assign b_sk[i]  = b_sh_q[i-1];
      assign av_sk[i] = av_sh_q[i-1];
      assign bv_sk[i] = bv_sh_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [ACC_W-1:0]    acc_q;
      logic [2*DATA_W-1:0] a_ext;
      logic [2*DATA_W-1:0] b_ext;
      logic [2*DATA_W-1:0] prod;
      logic [ACC_W-1:0]    prod_ext;
      logic [ACC_W:0]      sum;
      logic [ACC_W-1:0]    sat_val;
      logic [ACC_W-1:0]    acc_next;
      logic                fire;
      logic                ovf;

      if (j == 0) begin : g_a_edge
        assign a_pe[i][j]  = a_sk[i];
        assign av_pe[i][j] = av_sk[i];
      end
      if (i == 0) begin : g_b_edge
        assign b_pe[i][j]  = b_sk[j];
        assign bv_pe[i][j] = bv_sk[j];
      end

      if (j < N - 1) begin : g_a_fwd
        logic [DATA_W-1:0] a_fwd_q;
        logic              av_fwd_q;
        // Pass a to the right neighbour.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            a_fwd_q  <= '0;
            av_fwd_q <= 1'b0;
          end else begin
            a_fwd_q  <= a_pe[i][j];
            av_fwd_q <= av_pe[i][j];
          end
        end
        assign a_pe[i][j+1]  = a_fwd_q;
        assign av_pe[i][j+1] = av_fwd_q;
      end

      if (i < N - 1) begin : g_b_fwd
        logic [DATA_W-1:0] b_fwd_q;
        logic              bv_fwd_q;
        // Pass b to the neighbour below.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            b_fwd_q  <= '0;
            bv_fwd_q <= 1'b0;
          end else begin
            b_fwd_q  <= b_pe[i][j];
            bv_fwd_q <= bv_pe[i][j];
          end
        end
        assign b_pe[i+1][j]  = b_fwd_q;
        assign bv_pe[i+1][j] = bv_fwd_q;
      end

      // MAC datapath: the low 2*DATA_W bits of the extended product are exact.
      always_comb begin
        a_ext = {{DATA_W{SIGNED & a_pe[i][j][DATA_W-1]}}, a_pe[i][j]};
        b_ext = {{DATA_W{SIGNED & b_pe[i][j][DATA_W-1]}}, b_pe[i][j]};
        prod  = a_ext * b_ext;
        if (SIGNED) prod_ext = ACC_W'($signed(prod));
        else        prod_ext = ACC_W'(prod);
        sum = {SIGNED & acc_q[ACC_W-1], acc_q} + {SIGNED & prod_ext[ACC_W-1], prod_ext};
        if (SIGNED) begin
          ovf     = sum[ACC_W] ^ sum[ACC_W-1];
          sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          ovf     = sum[ACC_W];
          sat_val = '1;
        end
        acc_next = (SATURATE && ovf) ? sat_val : sum[ACC_W-1:0];
        fire     = av_pe[i][j] && bv_pe[i][j];
      end

      assign pe_ovf[i*N+j] = fire && ovf;
      assign acc[i][j]     = acc_q;

      // Accumulate only on valid operands; the final drain handshake clears.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          acc_q <= '0;
        end else if (drain_done) begin
          acc_q <= '0;
        end else if (fire) begin
          acc_q <= acc_next;
        end
      end
    end
  end

  // Row-serial result mux, zero outside DRAIN.
  always_comb begin
    c_o = '0;
    if (state_q == StDrain) begin
      for (int j = 0; j < N; j++) begin
        c_o[j*ACC_W +: ACC_W] = acc[row_q][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Scoreboard bench for systolic_tile_engine: four instances cover the main
// configuration, saturate/wrap overflow at ACC_W=16, and an unsigned N=1 tile.
module tb_systolic_tile_engine;

  typedef struct packed {
    logic [95:0] c;
    logic        last;
    logic        ovf;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        in_valid [4];
  logic        in_last  [4];
  logic [31:0] a_v      [4];
  logic [31:0] b_v      [4];
  logic        out_ready[4];

  logic        in_ready_w [4];
  logic        out_valid_w[4];
  logic        out_last_w [4];
  logic        ovf_w      [4];
  logic        busy_w     [4];
  logic [95:0] c_w        [4];

  logic [95:0] c_main;
  logic [63:0] c_sat;
  logic [63:0] c_wrp;
  logic [23:0] c_n1;

  row_t exp_q [4][$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign c_w[0] = c_main;
  assign c_w[1] = {32'b0, c_sat};
  assign c_w[2] = {32'b0, c_wrp};
  assign c_w[3] = {72'b0, c_n1};

  systolic_tile_engine #(.N(4), .DATA_W(8), .ACC_W(24), .SIGNED(1'b1), .SATURATE(1'b0),
                         .K_W(16)) u_main (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready_w[0]),
    .in_last_i(in_last[0]), .a_i(a_v[0]), .b_i(b_v[0]), .out_valid_o(out_valid_w[0]),
    .out_ready_i(out_ready[0]), .out_last_o(out_last_w[0]), .c_o(c_main), .ovf_o(ovf_w[0]),
    .busy_o(busy_w[0])
  );

  systolic_tile_engine #(.N(4), .DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1),
                         .K_W(16)) u_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready_w[1]),
    .in_last_i(in_last[1]), .a_i(a_v[1]), .b_i(b_v[1]), .out_valid_o(out_valid_w[1]),
    .out_ready_i(out_ready[1]), .out_last_o(out_last_w[1]), .c_o(c_sat), .ovf_o(ovf_w[1]),
    .busy_o(busy_w[1])
  );

  // Shares operand inputs with u_sat.
  systolic_tile_engine #(.N(4), .DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0),
                         .K_W(16)) u_wrp (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready_w[2]),
    .in_last_i(in_last[1]), .a_i(a_v[1]), .b_i(b_v[1]), .out_valid_o(out_valid_w[2]),
    .out_ready_i(out_ready[2]), .out_last_o(out_last_w[2]), .c_o(c_wrp), .ovf_o(ovf_w[2]),
    .busy_o(busy_w[2])
  );

  systolic_tile_engine #(.N(1), .DATA_W(8), .ACC_W(24), .SIGNED(1'b0), .SATURATE(1'b0),
                         .K_W(16)) u_n1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[3]), .in_ready_o(in_ready_w[3]),
    .in_last_i(in_last[3]), .a_i(a_v[3][7:0]), .b_i(b_v[3][7:0]),
    .out_valid_o(out_valid_w[3]), .out_ready_i(out_ready[3]), .out_last_o(out_last_w[3]),
    .c_o(c_n1), .ovf_o(ovf_w[3]), .busy_o(busy_w[3])
  );

  function automatic logic [31:0] pack4(int x0, int x1, int x2, int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic logic [95:0] packc(int c0, int c1, int c2, int c3);
    return {24'(c3), 24'(c2), 24'(c1), 24'(c0)};
  endfunction

  function automatic logic [95:0] pack16(int c0, int c1, int c2, int c3);
    return {32'b0, 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic chk(string name, logic [95:0] got, logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push_row(int k, logic [95:0] c, logic last, logic ovf);
    row_t e;
    e.c    = c;
    e.last = last;
    e.ovf  = ovf;
    exp_q[k].push_back(e);
  endtask

  task automatic check_row(int k, logic [95:0] c, logic last, logic ovf);
    row_t e;
    checks++;
    if (exp_q[k].size() == 0) begin
      failures++;
      $display("FAIL unexpected_row inst=%0d got c=%0h last=%0b ovf=%0b", k, c, last, ovf);
    end else begin
      e = exp_q[k].pop_front();
      if (c !== e.c || last !== e.last || ovf !== e.ovf) begin
        failures++;
        $display("FAIL row inst=%0d got c=%0h last=%0b ovf=%0b expected c=%0h last=%0b ovf=%0b",
                 k, c, last, ovf, e.c, e.last, e.ovf);
      end
    end
  endtask

  // Monitor: every row handshake is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid_w[k] && out_ready[k]) check_row(k, c_w[k], out_last_w[k], ovf_w[k]);
      end
    end
  end

  task automatic beat(int k, logic [31:0] a, logic [31:0] b, logic last, output int waited);
    in_valid[k] = 1'b1;
    in_last[k]  = last;
    a_v[k]      = a;
    b_v[k]      = b;
    waited      = 0;
    while (!in_ready_w[k] && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready_w[k]) begin
      checks++;
      failures++;
      $display("FAIL beat_accept inst=%0d got in_ready=0 required 1", k);
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic idle_cycle(int k);
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b1;
    @(posedge clk);
    #1;
    in_last[k]  = 1'b0;
  endtask

  // Waits until the tile finishes; lat = negedges until the first out_valid.
  task automatic wait_tile(int k, output int lat);
    bit done;
    bit rdy_bad;
    done    = 1'b0;
    rdy_bad = 1'b0;
    lat     = -1;
    for (int n = 1; n <= 300 && !done; n++) begin
      @(negedge clk);
      if (out_valid_w[k] && lat < 0) lat = n;
      if (!busy_w[k]) done = 1'b1;
      else if (in_ready_w[k]) rdy_bad = 1'b1;
    end
    checks++;
    if (!done || rdy_bad) begin
      failures++;
      $display("FAIL tile_end inst=%0d got done=%0b ready_while_busy=%0b required 1/0",
               k, done, rdy_bad);
    end
  endtask

  task automatic wait_valid(int k);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (out_valid_w[k]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_valid inst=%0d got out_valid=0 required 1", k);
    end
  endtask

  task automatic rst_chk(string tag);
    chk({tag, "_in_ready"},  96'(in_ready_w[0]),  96'd1);
    chk({tag, "_out_valid"}, 96'(out_valid_w[0]), 96'd0);
    chk({tag, "_out_last"},  96'(out_last_w[0]),  96'd0);
    chk({tag, "_c"},         c_w[0],              96'd0);
    chk({tag, "_ovf"},       96'(ovf_w[0]),       96'd0);
    chk({tag, "_busy"},      96'(busy_w[0]),      96'd0);
  endtask

  // Identity A, B[k][j] = 4k+j; optional bubble with in_last high between beats.
  task automatic ident_tile(bit bubbles);
    int w;
    for (int k = 0; k < 4; k++) begin
      beat(0, pack4(k == 0, k == 1, k == 2, k == 3), pack4(4*k, 4*k+1, 4*k+2, 4*k+3),
           k == 3, w);
      if (bubbles && k < 3) idle_cycle(0);
    end
  endtask

  task automatic push_ident(int nrows);
    for (int r = 0; r < nrows; r++) push_row(0, packc(4*r, 4*r+1, 4*r+2, 4*r+3), r == 3, 1'b0);
  endtask

  task automatic push_k1();
    for (int r = 0; r < 4; r++)
      push_row(0, packc(-(r+1), -(r+1), -(r+1), -(r+1)), r == 3, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int w;
    int vcount;
    for (int k = 0; k < 4; k++) begin
      in_valid[k]  = 1'b0;
      in_last[k]   = 1'b0;
      a_v[k]       = '0;
      b_v[k]       = '0;
      out_ready[k] = 1'b1;
    end
    #1 rst = 1'b1;
    #2;
    rst_chk("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Identity tile, contiguous beats.
    push_ident(4);
    ident_tile(1'b0);
    wait_tile(0, lat);
    chk("t1_latency", 96'(lat), 96'd8);

    // Same tile with bubbles.
    push_ident(4);
    ident_tile(1'b1);
    wait_tile(0, lat);
    chk("t2_latency", 96'(lat), 96'd8);

    // Backpressure on row 1 for five cycles.
    push_ident(4);
    ident_tile(1'b0);
    wait_valid(0);
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t4_hold_c",     c_w[0],              packc(4, 5, 6, 7));
      chk("t4_hold_last",  96'(out_last_w[0]),  96'd0);
      chk("t4_hold_valid", 96'(out_valid_w[0]), 96'd1);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    wait_tile(0, lat);
    chk("t4_ready_after", 96'(in_ready_w[0]), 96'd1);

    // K = 1 tile issued immediately after the drain.
    push_k1();
    beat(0, pack4(1, 2, 3, 4), pack4(-1, -1, -1, -1), 1'b1, w);
    chk("t3_accept_wait", 96'(w), 96'd0);
    wait_tile(0, lat);
    chk("t3_latency", 96'(lat), 96'd8);

    // Overflow: saturate and wrap instances, then a clean tile.
    for (int r = 0; r < 4; r++) begin
      push_row(1, pack16(32767, 32767, 32767, 32767), r == 3, 1'b1);
      push_row(2, pack16(-16384, -16384, -16384, -16384), r == 3, 1'b1);
    end
    for (int k = 0; k < 3; k++) beat(1, {4{8'h80}}, {4{8'h80}}, k == 2, w);
    wait_tile(1, lat);
    for (int r = 0; r < 4; r++) begin
      push_row(1, pack16(1, 1, 1, 1), r == 3, 1'b0);
      push_row(2, pack16(1, 1, 1, 1), r == 3, 1'b0);
    end
    beat(1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1, w);
    wait_tile(1, lat);

    // Reset during FLUSH.
    ident_tile(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    rst_chk("rst_flush");
    @(posedge clk);
    #1 rst = 1'b0;
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_w[0]) vcount++;
    end
    chk("rst_flush_no_output", 96'(vcount), 96'd0);

    // Reset while row 2 is presented.
    out_ready[0] = 1'b0;
    push_ident(2);
    ident_tile(1'b0);
    wait_valid(0);
    repeat (2) begin
      @(posedge clk);
      #1 out_ready[0] = 1'b1;
      @(posedge clk);
      #1 out_ready[0] = 1'b0;
    end
    @(negedge clk);
    chk("rst_drain_row2", c_w[0], packc(8, 9, 10, 11));
    rst = 1'b1;
    #1;
    rst_chk("rst_drain");
    chk("rst_drain_queue", 96'(exp_q[0].size()), 96'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready[0] = 1'b1;
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_w[0]) vcount++;
    end
    chk("rst_drain_no_output", 96'(vcount), 96'd0);
    push_k1();
    @(posedge clk);
    #1;
    beat(0, pack4(1, 2, 3, 4), pack4(-1, -1, -1, -1), 1'b1, w);
    wait_tile(0, lat);
    chk("post_rst_latency", 96'(lat), 96'd8);

    // N = 1 unsigned: 2 x 255 x 255.
    push_row(3, {72'b0, 24'd130050}, 1'b1, 1'b0);
    beat(3, 32'h0000_00ff, 32'h0000_00ff, 1'b0, w);
    beat(3, 32'h0000_00ff, 32'h0000_00ff, 1'b1, w);
    wait_tile(3, lat);
    chk("n1_latency", 96'(lat), 96'd2);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk("queue_empty", 96'(exp_q[k].size()), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
